// File: rtl/and5_bist.sv
// and5_bist: drives all 32 vectors onto a 5-input AND gate, checks dut_out, reports the results.
// Latency: SETTLE+2 cycles per vector, 32*(SETTLE+2) cycles from the start edge to done.
// Backpressure: none; start is ignored while busy. AND5_BIST_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module and5_bist #(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_out,
  output logic             in1,
  output logic             in2,
  output logic             in3,
  output logic             in4,
  output logic             in5,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [4:0]       first_fail_vec,
  output logic             first_fail_valid
);

  // The settle counter always gets at least one bit, so SETTLE=0 still elaborates.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state;
  logic [4:0]      vec;
  logic [CW-1:0]   cnt;
  logic            mismatch;
  logic [ERR_W-1:0] err_next;

  // The vector register drives the gate inputs directly; in1 is the MSB.
  assign {in1, in2, in3, in4, in5} = vec;

  // Case equality makes an X or Z on dut_out count as a mismatch.
  assign mismatch = !(dut_out === (&vec));

  // The error count saturates at all-ones, so pass stays 0 once anything failed.
  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_next = err_cnt + 1'b1;
    end
  end

  // Sweep sequencer: apply, settle, sample, advance; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      vec              <= 5'd0;
      cnt              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= '0;
      first_fail_vec   <= 5'd0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_cnt          <= '0;
            first_fail_vec   <= 5'd0;
            first_fail_valid <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            vec              <= 5'd0;
            busy             <= 1'b1;
            state            <= S_APPLY;
          end
        end
        S_APPLY: begin
          cnt   <= CW'(SETTLE);
          state <= (SETTLE > 0) ? S_WAIT : S_SAMPLE;
        end
        S_WAIT: begin
          if (cnt <= CW'(1)) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SAMPLE: begin
          err_cnt <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
`ifdef AND5_BIST_STOP_ON_FAIL_EN
          if (mismatch || (vec == 5'd31)) begin
`else
          if (vec == 5'd31) begin
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            vec   <= vec + 5'd1;
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and5_bist.sv
// tb_and5_bist: two engines (SETTLE=2/ERR_W=6 and SETTLE=0/ERR_W=4) each driving a selectable gate model.
// Latency: sweeps are timed from the start edge to done in whole clock cycles.
// Backpressure: none; the bench pokes start mid-sweep to confirm it is ignored.
module tb_and5_bist;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1;
  logic [1:0] mode0, mode1;   // 0: ideal AND, 1: tied 0, 2: tied 1
  logic dout0, dout1;

  logic a_in1, a_in2, a_in3, a_in4, a_in5, a_busy, a_done, a_pass, a_ffv;
  logic [5:0] a_err;
  logic [4:0] a_ffvec;
  logic b_in1, b_in2, b_in3, b_in4, b_in5, b_busy, b_done, b_pass, b_ffv;
  logic [3:0] b_err;
  logic [4:0] b_ffvec;

  logic [4:0] vec_a, vec_b;
  assign vec_a = {a_in1, a_in2, a_in3, a_in4, a_in5};
  assign vec_b = {b_in1, b_in2, b_in3, b_in4, b_in5};

  assign dout0 = (mode0 == 2'd0) ? (&vec_a) : (mode0 == 2'd2);
  assign dout1 = (mode1 == 2'd0) ? (&vec_b) : (mode1 == 2'd2);

  always #5 clk = ~clk;

  and5_bist #(.SETTLE(2), .ERR_W(6)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_out(dout0),
    .in1(a_in1), .in2(a_in2), .in3(a_in3), .in4(a_in4), .in5(a_in5),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err),
    .first_fail_vec(a_ffvec), .first_fail_valid(a_ffv)
  );

  and5_bist #(.SETTLE(0), .ERR_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_out(dout1),
    .in1(b_in1), .in2(b_in2), .in3(b_in3), .in4(b_in4), .in5(b_in5),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
    .first_fail_vec(b_ffvec), .first_fail_valid(b_ffv)
  );

  typedef struct {
    logic       sel;     // 0: engine A, 1: engine B
    logic [1:0] mode;
    int         poke;    // cycle after start at which start is pulsed again (0 = never)
    int         cyc;
    int         err;
    logic       pss;
    logic       ffv;
    logic [4:0] ffvec;
    logic [4:0] endvec;
  } vec_t;

  vec_t tbl [8];
  vec_t exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] g_vec(input logic s);   return s ? vec_b : vec_a;       endfunction
  function automatic logic g_done(input logic s);        return s ? b_done : a_done;     endfunction
  function automatic logic g_busy(input logic s);        return s ? b_busy : a_busy;     endfunction
  function automatic logic g_pass(input logic s);        return s ? b_pass : a_pass;     endfunction
  function automatic logic g_ffv(input logic s);         return s ? b_ffv : a_ffv;       endfunction
  function automatic logic [4:0] g_ffvec(input logic s); return s ? b_ffvec : a_ffvec;   endfunction
  function automatic int g_err(input logic s);           return s ? int'(b_err) : int'(a_err); endfunction

  // One full sweep: expectation queued at start, popped and compared when done rises.
  task automatic run(input vec_t t);
    vec_t e;
    int cyc;
    int steps_ok;
    logic [4:0] pv;
    if (t.sel) mode1 = t.mode; else mode0 = t.mode;
    exp_q.push_back(t);
    @(negedge clk);
    if (t.sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    check("busy_after_start", g_busy(t.sel), 1);
    check("done_cleared", g_done(t.sel), 0);
    check("err_cleared", g_err(t.sel), 0);
    check("ffv_cleared", g_ffv(t.sel), 0);
    check("vec_start", g_vec(t.sel), 0);
    cyc = 0; pv = 5'd0; steps_ok = 1;
    while (!g_done(t.sel) && cyc < 1000) begin
      if (t.poke != 0 && cyc == t.poke) begin
        if (t.sel) start1 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start1 = 1'b0;
      cyc++;
      if (g_vec(t.sel) != pv && int'(g_vec(t.sel)) != int'(pv) + 1) steps_ok = 0;
      pv = g_vec(t.sel);
    end
    e = exp_q.pop_front();
    check("sweep_cycles", cyc, e.cyc);
    check("err_cnt", g_err(t.sel), e.err);
    check("pass", g_pass(t.sel), e.pss);
    check("first_fail_valid", g_ffv(t.sel), e.ffv);
    check("first_fail_vec", g_ffvec(t.sel), e.ffvec);
    check("end_vec", g_vec(t.sel), e.endvec);
    check("busy_at_done", g_busy(t.sel), 0);
    check("vec_stepping", steps_ok, 1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; mode0 = 2'd0; mode1 = 2'd0;

    //                sel   mode  poke cyc err  pass  ffv   ffvec  endvec
    tbl[0] = '{1'b0, 2'd0, 0,  128, 0,  1'b1, 1'b0, 5'd0,  5'd31};
    tbl[1] = '{1'b0, 2'd0, 50, 128, 0,  1'b1, 1'b0, 5'd0,  5'd31};
    tbl[2] = '{1'b0, 2'd1, 0,  128, 1,  1'b0, 1'b1, 5'd31, 5'd31};
`ifdef AND5_BIST_STOP_ON_FAIL_EN
    tbl[3] = '{1'b0, 2'd2, 0,  4,   1,  1'b0, 1'b1, 5'd0,  5'd0};
`else
    tbl[3] = '{1'b0, 2'd2, 0,  128, 31, 1'b0, 1'b1, 5'd0,  5'd31};
`endif
    tbl[4] = '{1'b0, 2'd0, 0,  128, 0,  1'b1, 1'b0, 5'd0,  5'd31};
    tbl[5] = '{1'b1, 2'd0, 20, 64,  0,  1'b1, 1'b0, 5'd0,  5'd31};
`ifdef AND5_BIST_STOP_ON_FAIL_EN
    tbl[6] = '{1'b1, 2'd2, 0,  2,   1,  1'b0, 1'b1, 5'd0,  5'd0};
`else
    tbl[6] = '{1'b1, 2'd2, 0,  64,  15, 1'b0, 1'b1, 5'd0,  5'd31};
`endif
    tbl[7] = '{1'b1, 2'd1, 0,  64,  1,  1'b0, 1'b1, 5'd31, 5'd31};

    #23;
    check("reset_state_a", int'({vec_a, a_busy, a_done, a_pass, a_err, a_ffvec, a_ffv}), 0);
    check("reset_state_b", int'({vec_b, b_busy, b_done, b_pass, b_err, b_ffvec, b_ffv}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(tbl[i]);
    end

    // Reset in the middle of a sweep, then confirm a clean full sweep follows.
    mode0 = 2'd2;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    k = 0;
    while (vec_a != 5'd10 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_vec10", int'(vec_a), 10);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_a", int'({vec_a, a_busy, a_done, a_pass, a_err, a_ffvec, a_ffv}), 0);
    check("async_reset_b", int'({vec_b, b_busy, b_done, b_pass, b_err, b_ffvec, b_ffv}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
